// File: rtl/nibble_bus_arbiter_if.sv
// Bundle of requester handshakes and external memory-bus pins for nibble_bus_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of the
// requesters and the memory side.
interface nibble_bus_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 4
) ();
    // Requester 0 (CPU core)
    logic              m0_req;
    logic              m0_lock;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    // Requester 1 (debug / program loader)
    logic              m1_req;
    logic              m1_lock;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    // External memory bus
    logic [ADDR_W-1:0] ext_addr;
    logic [1:0]        ext_cmd;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_oe;
    logic [DATA_W-1:0] ext_rdata;

    // Status
    logic              grant_id;
    logic              busy;

    modport slave (
        input  m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
        input  ext_rdata,
        output m0_ack, m0_rdata, m1_ack, m1_rdata,
        output ext_addr, ext_cmd, ext_wdata, ext_oe,
        output grant_id, busy
    );

    modport master (
        output m0_req, m0_lock, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_lock, m1_we, m1_addr, m1_wdata,
        output ext_rdata,
        input  m0_ack, m0_rdata, m1_ack, m1_rdata,
        input  ext_addr, ext_cmd, ext_wdata, ext_oe,
        input  grant_id, busy
    );
endinterface

// File: rtl/nibble_bus_arbiter.sv
// Two-requester arbiter and sequencer for the shared nibble-wide external memory bus.
// Each access runs IDLE -> ADDR -> (WAIT x WAIT_CYCLES) -> DATA. Round-robin
// arbitration is used, and a locked burst lets one owner take up to MAX_LOCK
// accesses back-to-back.
module nibble_bus_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 4,
    parameter int WAIT_CYCLES = 0,
    parameter int MAX_LOCK    = 3
) (
    input logic                 clk,
    input logic                 rst_n,
    nibble_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_WAIT = 2'd2,
        S_DATA = 2'd3
    } state_t;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b11;

    // The last WAIT count value. It only matters when WAIT_CYCLES > 0.
    localparam logic [2:0] WAIT_LAST = 3'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    // Burst count value at which the next locked DATA edge ends the burst.
    localparam logic [2:0] LOCK_LAST = 3'(MAX_LOCK - 1);

    state_t            state_q, state_d;
    logic [2:0]        wait_cnt_q, wait_cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_id_q, grant_id_d;
    logic              lock_active_q, lock_active_d;
    logic              lock_owner_q, lock_owner_d;
    logic [2:0]        burst_cnt_q, burst_cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] ext_addr_q, ext_addr_d;
    logic [1:0]        ext_cmd_q, ext_cmd_d;
    logic [DATA_W-1:0] ext_wdata_q, ext_wdata_d;
    logic              ext_oe_q, ext_oe_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;

    logic [1:0]        req_vec;
    logic [1:0]        lock_vec;
    logic              grant_valid;
    logic              winner;

    assign req_vec  = {bus.m1_req,  bus.m0_req};
    assign lock_vec = {bus.m1_lock, bus.m0_lock};

    // State register: holds the FSM state, the latched request, the lock
    // bookkeeping and the registered bus outputs.
    // NOTE: flops are updated with non-blocking assignments only. This way every
    // always_ff samples the pre-edge values, whatever order the blocks run in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            last_grant_q  <= 1'b1;
            grant_id_q    <= 1'b0;
            lock_active_q <= 1'b0;
            lock_owner_q  <= 1'b0;
            burst_cnt_q   <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            ext_addr_q    <= '0;
            ext_cmd_q     <= CMD_IDLE;
            ext_wdata_q   <= '0;
            ext_oe_q      <= 1'b0;
            m0_ack_q      <= 1'b0;
            m1_ack_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            last_grant_q  <= last_grant_d;
            grant_id_q    <= grant_id_d;
            lock_active_q <= lock_active_d;
            lock_owner_q  <= lock_owner_d;
            burst_cnt_q   <= burst_cnt_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            ext_addr_q    <= ext_addr_d;
            ext_cmd_q     <= ext_cmd_d;
            ext_wdata_q   <= ext_wdata_d;
            ext_oe_q      <= ext_oe_d;
            m0_ack_q      <= m0_ack_d;
            m1_ack_q      <= m1_ack_d;
        end
    end

    // Next-state logic: arbitration in IDLE, phase sequencing, and lock/burst update at DATA.
    // NOTE: every variable assigned here gets a default first, so that no path
    // leaves one unassigned and infers a latch.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        last_grant_d  = last_grant_q;
        grant_id_d    = grant_id_q;
        lock_active_d = lock_active_q;
        lock_owner_d  = lock_owner_q;
        burst_cnt_d   = burst_cnt_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        grant_valid   = 1'b0;
        winner        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (lock_active_q && req_vec[lock_owner_q]) begin
                    grant_valid = 1'b1;
                    winner      = lock_owner_q;
                end else begin
                    // An idle lock owner gives up the burst. Normal
                    // round-robin then applies in this same cycle.
                    if (lock_active_q) begin
                        lock_active_d = 1'b0;
                        burst_cnt_d   = '0;
                    end
                    if (req_vec == 2'b11) begin
                        grant_valid = 1'b1;
                        winner      = ~last_grant_q;
                    end else if (req_vec[0]) begin
                        grant_valid = 1'b1;
                        winner      = 1'b0;
                    end else if (req_vec[1]) begin
                        grant_valid = 1'b1;
                        winner      = 1'b1;
                    end
                end

                if (grant_valid) begin
                    grant_id_d   = winner;
                    last_grant_d = winner;
                    we_d         = winner ? bus.m1_we    : bus.m0_we;
                    addr_d       = winner ? bus.m1_addr  : bus.m0_addr;
                    wdata_d      = winner ? bus.m1_wdata : bus.m0_wdata;
                    state_d      = S_ADDR;
                end
            end

            S_ADDR: begin
                wait_cnt_d = '0;
                state_d    = (WAIT_CYCLES > 0) ? S_WAIT : S_DATA;
            end

            S_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_DATA;
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end

            S_DATA: begin
                state_d = S_IDLE;
                // The lock is sampled live from the owner at the completing
                // edge. When the burst reaches its limit, the other requester
                // gets a turn.
                if (lock_vec[grant_id_q] && (burst_cnt_q < LOCK_LAST)) begin
                    lock_active_d = 1'b1;
                    lock_owner_d  = grant_id_q;
                    burst_cnt_d   = burst_cnt_q + 3'd1;
                end else begin
                    lock_active_d = 1'b0;
                    burst_cnt_d   = '0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: registered bus outputs are decoded from the upcoming state,
    // so that they line up with the state they belong to.
    always_comb begin
        ext_addr_d  = ext_addr_q;
        ext_cmd_d   = CMD_IDLE;
        ext_wdata_d = '0;
        ext_oe_d    = 1'b0;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;

        if (state_d != S_IDLE) begin
            ext_addr_d = addr_d;
            ext_cmd_d  = we_d ? CMD_WRITE : CMD_READ;
        end

        if (state_d == S_DATA) begin
            ext_oe_d    = we_d;
            ext_wdata_d = we_d ? wdata_d : '0;
            m0_ack_d    = ~grant_id_d;
            m1_ack_d    = grant_id_d;
        end
    end

    assign bus.ext_addr  = ext_addr_q;
    assign bus.ext_cmd   = ext_cmd_q;
    assign bus.ext_wdata = ext_wdata_q;
    assign bus.ext_oe    = ext_oe_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.m0_ack    = m0_ack_q;
    assign bus.m1_ack    = m1_ack_q;

    // Read data is passed through only during the owner's ack of a read.
    assign bus.m0_rdata = (m0_ack_q && !we_q) ? bus.ext_rdata : '0;
    assign bus.m1_rdata = (m1_ack_q && !we_q) ? bus.ext_rdata : '0;

endmodule

// File: tb/tb_nibble_bus_arbiter.sv
// Directed self-checking bench for nibble_bus_arbiter. The bench uses one instance
// with no wait states and one instance with two wait states.
module tb_nibble_bus_arbiter;

    logic clk;
    logic rst_n;

    int n_cmp;
    int n_err;

    nibble_bus_arbiter_if #(.ADDR_W(10), .DATA_W(4)) bus ();
    nibble_bus_arbiter_if #(.ADDR_W(10), .DATA_W(4)) bus_w ();

    nibble_bus_arbiter #(
        .ADDR_W(10), .DATA_W(4), .WAIT_CYCLES(0), .MAX_LOCK(3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    nibble_bus_arbiter #(
        .ADDR_W(10), .DATA_W(4), .WAIT_CYCLES(2), .MAX_LOCK(3)
    ) dut_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.m0_req = 0; bus.m0_lock = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 0; bus.m1_lock = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
        bus.ext_rdata = 4'hA;
        bus_w.m0_req = 0; bus_w.m0_lock = 0; bus_w.m0_we = 0; bus_w.m0_addr = '0; bus_w.m0_wdata = '0;
        bus_w.m1_req = 0; bus_w.m1_lock = 0; bus_w.m1_we = 0; bus_w.m1_addr = '0; bus_w.m1_wdata = '0;
        bus_w.ext_rdata = 4'h3;

        // ---- reset state ----
        repeat (2) tick();
        check("rst_ext_cmd",  16'(bus.ext_cmd),  16'h0);
        check("rst_ext_addr", 16'(bus.ext_addr), 16'h0);
        check("rst_ext_oe",   16'(bus.ext_oe),   16'h0);
        check("rst_grant_id", 16'(bus.grant_id), 16'h0);
        check("rst_busy",     16'(bus.busy),     16'h0);
        check("rst_acks",     16'({bus.m1_ack, bus.m0_ack}), 16'h0);
        rst_n = 1'b1;
        tick();

        // ---- m0 read 0x155, ext_rdata = 0xA ----
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 10'h155;
        tick();  // ADDR
        check("rd_addr_cmd",   16'(bus.ext_cmd),  16'h1);
        check("rd_addr_addr",  16'(bus.ext_addr), 16'h155);
        check("rd_addr_oe",    16'(bus.ext_oe),   16'h0);
        check("rd_addr_ack",   16'(bus.m0_ack),   16'h0);
        check("rd_addr_busy",  16'(bus.busy),     16'h1);
        tick();  // DATA
        check("rd_data_cmd",   16'(bus.ext_cmd),  16'h1);
        check("rd_data_ack",   16'(bus.m0_ack),   16'h1);
        check("rd_data_rdata", 16'(bus.m0_rdata), 16'hA);
        check("rd_data_oe",    16'(bus.ext_oe),   16'h0);
        check("rd_data_m1ack", 16'(bus.m1_ack),   16'h0);
        check("rd_data_gid",   16'(bus.grant_id), 16'h0);
        bus.m0_req = 0;
        tick();  // IDLE
        check("rd_idle_cmd",   16'(bus.ext_cmd),  16'h0);
        check("rd_idle_ack",   16'(bus.m0_ack),   16'h0);
        check("rd_idle_rdata", 16'(bus.m0_rdata), 16'h0);
        check("rd_idle_busy",  16'(bus.busy),     16'h0);

        // ---- m1 write 0x3FF data 0x5 ----
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 10'h3FF; bus.m1_wdata = 4'h5;
        tick();  // ADDR
        check("wr_addr_cmd",   16'(bus.ext_cmd),   16'h3);
        check("wr_addr_addr",  16'(bus.ext_addr),  16'h3FF);
        check("wr_addr_oe",    16'(bus.ext_oe),    16'h0);
        check("wr_addr_wdata", 16'(bus.ext_wdata), 16'h0);
        check("wr_addr_gid",   16'(bus.grant_id),  16'h1);
        tick();  // DATA
        check("wr_data_cmd",   16'(bus.ext_cmd),   16'h3);
        check("wr_data_oe",    16'(bus.ext_oe),    16'h1);
        check("wr_data_wdata", 16'(bus.ext_wdata), 16'h5);
        check("wr_data_m1ack", 16'(bus.m1_ack),    16'h1);
        check("wr_data_m0ack", 16'(bus.m0_ack),    16'h0);
        check("wr_data_rdata", 16'(bus.m1_rdata),  16'h0);
        bus.m1_req = 0; bus.m1_we = 0;
        tick();  // IDLE
        check("wr_idle_oe",    16'(bus.ext_oe),    16'h0);
        check("wr_idle_cmd",   16'(bus.ext_cmd),   16'h0);

        // ---- reset during DATA of an m0 write (last grant is m0 before reset) ----
        bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 10'h0AA; bus.m0_wdata = 4'hC;
        tick();  // ADDR
        tick();  // DATA
        check("rw_data_oe",    16'(bus.ext_oe), 16'h1);
        check("rw_data_ack",   16'(bus.m0_ack), 16'h1);
        rst_n = 1'b0;
        #1;
        check("rw_rst_cmd",    16'(bus.ext_cmd), 16'h0);
        check("rw_rst_oe",     16'(bus.ext_oe),  16'h0);
        check("rw_rst_ack",    16'({bus.m1_ack, bus.m0_ack}), 16'h0);
        check("rw_rst_busy",   16'(bus.busy),    16'h0);
        bus.m0_req = 0; bus.m0_we = 0;
        tick();

        // ---- both requesting after reset: grants 0,1,0,1, acks 3 cycles apart ----
        bus.m0_req = 1; bus.m0_addr = 10'h011;
        bus.m1_req = 1; bus.m1_addr = 10'h022;
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            logic exp_m0, exp_m1;
            tick();
            exp_m0 = (k % 3 == 2) && ((k / 3) % 2 == 0);
            exp_m1 = (k % 3 == 2) && ((k / 3) % 2 == 1);
            check($sformatf("rr_m0ack_k%0d", k), 16'(bus.m0_ack), 16'(exp_m0));
            check($sformatf("rr_m1ack_k%0d", k), 16'(bus.m1_ack), 16'(exp_m1));
            if (k % 3 == 1)
                check($sformatf("rr_gid_k%0d", k), 16'(bus.grant_id), 16'((k / 3) % 2));
            if (k == 12) begin
                bus.m0_req = 0; bus.m1_req = 0;
            end
        end
        tick();
        check("rr_idle_busy", 16'(bus.busy), 16'h0);

        // ---- locked burst: m0 x3, then m1, then m0 ----
        bus.m0_req = 1; bus.m0_lock = 1; bus.m1_req = 1;
        for (int a = 0; a < 5; a++) begin
            logic exp_owner;
            exp_owner = (a == 3);
            tick();  // ADDR
            check($sformatf("lk_gid_a%0d", a), 16'(bus.grant_id), 16'(exp_owner));
            tick();  // DATA
            check($sformatf("lk_m0ack_a%0d", a), 16'(bus.m0_ack), 16'(!exp_owner));
            check($sformatf("lk_m1ack_a%0d", a), 16'(bus.m1_ack), 16'(exp_owner));
            if (a == 4) begin
                bus.m0_req = 0; bus.m0_lock = 0; bus.m1_req = 0;
            end
            tick();  // IDLE
        end

        // ---- two wait states: ext_cmd=01 for 4 cycles, ack in the 4th ----
        bus_w.m0_req = 1; bus_w.m0_we = 0; bus_w.m0_addr = 10'h0F0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("ws_cmd_k%0d", k), 16'(bus_w.ext_cmd), (k <= 4) ? 16'h1 : 16'h0);
            check($sformatf("ws_ack_k%0d", k), 16'(bus_w.m0_ack),  (k == 4) ? 16'h1 : 16'h0);
            if (k == 4) begin
                check("ws_rdata", 16'(bus_w.m0_rdata), 16'h3);
                bus_w.m0_req = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
